// File: rtl/serializer_pkg.sv
// Shared widths and state encoding for the serial link transmitter.
// The deserializer on the far end uses the same field widths.
package serializer_pkg;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 16;
    localparam int FRAME_W   = ADDR_W + DATA_W;
    localparam int BIT_CNT_W = 5;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Frame layout: address in the top bits, data below, sent MSB-first.
    function automatic logic [FRAME_W-1:0] make_frame(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {addr, data};
    endfunction

endpackage

// File: rtl/serializer_if.sv
// Parallel word handshake between the register/response logic and the serializer.
interface serializer_if;
    import serializer_pkg::*;

    logic [ADDR_W-1:0] P_ADDR;
    logic [DATA_W-1:0] P_DATA;
    logic              P_VALID;
    logic              P_READY;

    modport master (output P_ADDR, output P_DATA, output P_VALID, input P_READY);
    modport slave  (input P_ADDR, input P_DATA, input P_VALID, output P_READY);

endinterface

// File: rtl/serializer_tx_hold_reg.sv
// One-entry holding buffer in front of the shifter. Accepts a frame while
// empty and is released when the shifter takes the frame.
module tx_hold_reg
    import serializer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FRAME_W-1:0] in_frame,
    output logic               out_valid,
    output logic [FRAME_W-1:0] out_frame,
    input  logic               out_release
);

    logic               valid_r;
    logic [FRAME_W-1:0] frame_r;

    // Fill on an offered word while empty; empty again when the shifter loads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            frame_r <= {FRAME_W{1'b0}};
        end else if (out_release) begin
            valid_r <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_r <= 1'b1;
            frame_r <= in_frame;
        end
    end

    assign in_ready  = !valid_r;
    assign out_valid = valid_r;
    assign out_frame = frame_r;

endmodule

// File: rtl/serializer.sv
// Serial link transmitter: takes parallel address/data words and sends each
// as a 19-bit MSB-first frame with TX_LOAD on the last bit and TX_STOP when idle.
module serializer
    import serializer_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic              RST,
    input  logic              RX_CLK,
    serializer_if.slave       bus,
    output logic              TX_DATA,
    output logic              TX_LOAD,
    output logic              TX_STOP,
    output logic              TX_BUSY,
    output logic [CNT_W-1:0]  TX_CNT,
    output logic [DATA_W-1:0] t_data_mon
);

    localparam bit                   HAS_GAP  = (GAP > 0);
    localparam logic [7:0]           GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic [BIT_CNT_W-1:0] BIT_TOP  = BIT_CNT_W'(FRAME_W - 1);

    state_t                 state_r, state_n;
    logic [FRAME_W-1:0]     shift_r, shift_n;
    logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_n;
    logic [7:0]             gap_cnt_r, gap_cnt_n;
    logic                   tx_data_r, tx_load_r, tx_stop_r, tx_busy_r;
    logic                   tx_data_n, tx_load_n, tx_stop_n, tx_busy_n, tx_on_n;
    logic [CNT_W-1:0]       tx_cnt_r;
    logic [DATA_W-1:0]      mon_r;

    logic                   accept_s, can_load_s, start_s, frame_done_s;
    logic                   hold_valid_s, hold_ready_s, hold_wr_s, hold_rel_s;
    logic [FRAME_W-1:0]     hold_frame_s, bus_frame_s, load_word_s;

    assign bus_frame_s  = make_frame(bus.P_ADDR, bus.P_DATA);
    assign accept_s     = bus.P_VALID && hold_ready_s;
    assign bus.P_READY  = hold_ready_s;
    // A word goes straight into a free shifter; otherwise it waits in hold.
    assign hold_wr_s    = accept_s && !start_s;
    assign hold_rel_s   = start_s && hold_valid_s;
    assign load_word_s  = hold_valid_s ? hold_frame_s : bus_frame_s;

    tx_hold_reg u_hold (
        .clk         (RX_CLK),
        .rst         (RST),
        .in_valid    (hold_wr_s),
        .in_ready    (hold_ready_s),
        .in_frame    (bus_frame_s),
        .out_valid   (hold_valid_s),
        .out_frame   (hold_frame_s),
        .out_release (hold_rel_s)
    );

    // Next-state, shifter/counter update and next values of the registered outputs.
    always_comb begin
        state_n      = state_r;
        shift_n      = shift_r;
        bit_cnt_n    = bit_cnt_r;
        gap_cnt_n    = gap_cnt_r;
        can_load_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                can_load_s = 1'b1;
            end
            ST_SHIFT: begin
                if (bit_cnt_r == {BIT_CNT_W{1'b0}}) begin
                    frame_done_s = 1'b1;
                    if (HAS_GAP) begin
                        state_n   = ST_GAP;
                        gap_cnt_n = GAP_LAST;
                    end else begin
                        state_n    = ST_IDLE;
                        can_load_s = 1'b1;
                    end
                end else begin
                    shift_n   = {shift_r[FRAME_W-2:0], 1'b0};
                    bit_cnt_n = bit_cnt_r - 5'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 8'd0) begin
                    state_n    = ST_IDLE;
                    can_load_s = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt_r - 8'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A free shifter takes the held word first, else a word offered this edge.
        start_s = can_load_s && (hold_valid_s || accept_s);
        if (start_s) begin
            state_n   = ST_SHIFT;
            shift_n   = load_word_s;
            bit_cnt_n = BIT_TOP;
        end else begin
            state_n   = state_n;
        end

        tx_on_n   = (state_n == ST_SHIFT);
        tx_data_n = tx_on_n && shift_n[FRAME_W-1];
        tx_load_n = tx_on_n && (bit_cnt_n == {BIT_CNT_W{1'b0}});
        tx_stop_n = !tx_on_n;
        tx_busy_n = tx_on_n || (hold_valid_s && !hold_rel_s) || hold_wr_s;
    end

    // State, shifter, counters and registered line outputs.
    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            shift_r   <= {FRAME_W{1'b0}};
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            gap_cnt_r <= 8'd0;
            tx_data_r <= 1'b0;
            tx_load_r <= 1'b0;
            tx_stop_r <= 1'b1;
            tx_busy_r <= 1'b0;
            tx_cnt_r  <= {CNT_W{1'b0}};
            mon_r     <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_n;
            shift_r   <= shift_n;
            bit_cnt_r <= bit_cnt_n;
            gap_cnt_r <= gap_cnt_n;
            tx_data_r <= tx_data_n;
            tx_load_r <= tx_load_n;
            tx_stop_r <= tx_stop_n;
            tx_busy_r <= tx_busy_n;
            if (frame_done_s) begin
                tx_cnt_r <= tx_cnt_r + 16'd1;
            end
            if (accept_s) begin
                mon_r <= bus.P_DATA;
            end
        end
    end

    assign TX_DATA    = tx_data_r;
    assign TX_LOAD    = tx_load_r;
    assign TX_STOP    = tx_stop_r;
    assign TX_BUSY    = tx_busy_r;
    assign TX_CNT     = tx_cnt_r;
    assign t_data_mon = mon_r;

endmodule

// File: doc/serializer.md
# serializer

Transmit-side counterpart of the link deserializer. The block accepts parallel address/data words through a valid/ready handshake and buffers one word. It shifts each word out MSB-first as a 19-bit serial frame on TX_DATA, with TX_LOAD marking the last bit and TX_STOP marking link idle. It sits between the board's register/response logic and the serial link driver. Looped back into the deserializer, each frame yields exactly one P_ENA pulse carrying the original address and data.

## Interface
- ADDR_W, 3: address field width.
- DATA_W, 16: data field width. Frame width FRAME_W = ADDR_W + DATA_W = 19.
- GAP, 1: idle cycles inserted between consecutive frames (0 allowed).

Ports:
- RST  in  1  reset, asynchronous, active-low.
- RX_CLK  in  1  clock; all logic on its rising edge.
- P_ADDR  in  ADDR_W  address to send.
- P_DATA  in  DATA_W  data to send.
- P_VALID  in  1  word present on P_ADDR/P_DATA.
- P_READY  out  1  block can accept a word; a transfer occurs on any edge where P_VALID && P_READY.
- TX_DATA  out  1  serial bit, registered.
- TX_LOAD  out  1  high during the cycle carrying frame bit 0, registered.
- TX_STOP  out  1  high while no frame bit is on the line (IDLE/GAP), registered.
- TX_BUSY  out  1  shifter or holding register occupied.
- TX_CNT  out  16  frames fully sent; wraps at 0xFFFF to 0.
- t_data_mon  out  16  P_DATA of the last accepted word, for signaltap.

## Operation
- Frame = {P_ADDR, P_DATA}. Bit 18 is sent first and bit 0 last, one bit per RX_CLK cycle.
- Storage: 19-bit shift register plus a 1-entry holding register (hold_valid). P_READY = !hold_valid, which is combinational.
- State machine IDLE / SHIFT / GAP, with a 5-bit bit counter (18 down to 0) and a gap counter.
  - IDLE: on accept, the word loads directly into the shifter, the counter is set to 18, and the state goes to SHIFT. The holding register stays empty.
  - SHIFT: drive shifter MSB each cycle; shift left and decrement. At counter = 0, TX_LOAD is high for that cycle and TX_CNT increments.
    - After bit 0 with GAP > 0: go to GAP.
    - After bit 0 with GAP = 0 and hold_valid: load from hold and stay in SHIFT.
    - After bit 0 with GAP = 0 and hold empty: go to IDLE.
  - GAP: TX_DATA = 0, TX_LOAD = 0, TX_STOP = 1 for GAP cycles. Then load from hold (SHIFT) if hold_valid, otherwise go to IDLE.
- An accept while the shifter is busy writes the holding register.
- A word entering the shifter from hold releases the holding register on the same edge. P_READY rises the next cycle; same-edge refill is not supported.
- t_data_mon updates on every accept.

## Timing
- Reset values: TX_DATA 0, TX_LOAD 0, TX_STOP 1, TX_BUSY 0, TX_CNT 0, t_data_mon 0, hold_valid 0 (P_READY 1), state IDLE.
- Latency: accept at edge k (from IDLE) puts bit 18 on TX_DATA from edge k to k+1. Bit 0 and TX_LOAD are driven from edge k+18 to k+19.
- TX_STOP falls at edge k and rises at edge k+19.
- Frame period with back-to-back supply: 19 + GAP cycles.
- Reset asserted mid-frame: asynchronous return to reset values. The partial frame is aborted without TX_LOAD, the held word is discarded, and TX_CNT is cleared. The far-end receiver therefore produces no P_ENA.
- P_VALID deasserted without a transfer has no effect. P_ADDR/P_DATA are sampled only at the transfer edge.
- TX_CNT wrap: 0xFFFF + 1 = 0x0000, with no flag.

## Structure
- Shared package: ADDR_W, DATA_W, FRAME_W constants and the state enum {IDLE, SHIFT, GAP}. The deserializer uses the same field widths.
- One natural sub-module: tx_hold_reg, a 1-entry holding buffer with valid/ready in and a load/release port to the shifter. FSM, shifter and counters stay in the top.

## Test plan
- Single word: addr 5, data 0xA5C3.
  - TX_DATA = 1,0,1,1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over 19 cycles starting at the edge after accept.
  - TX_LOAD is high only on the 19th bit; TX_STOP is low for exactly 19 cycles; TX_CNT = 1.
- Loopback into the deserializer: words (1, 0x0001), (7, 0xFFFF), (0, 0x8000) sent back-to-back.
  - Three single-cycle P_ENA pulses with matching P_ADDR/P_DATA; t_data_mon ends at 0x8000.
- Back-to-back with GAP = 1: P_VALID held high for 3 words.
  - Frames are separated by exactly 1 TX_STOP cycle.
  - P_READY is low while hold is full and rises the cycle after hold drains.
- GAP = 0: two words.
  - The second frame's bit 18 immediately follows the first frame's TX_LOAD cycle; 38 consecutive TX_STOP-low cycles.
- Reset after bit 10 of frame 0x3_1234 with a second word held.
  - Outputs return to reset values immediately; no TX_LOAD; TX_CNT = 0.
  - The next accept after reset starts a clean frame.
- Wrap: TX_CNT forced or driven to 0xFFFF, then one frame sent → TX_CNT = 0x0000.
